// File: rtl/lcd_bcd_pkg.sv
// Shared definitions for the LCD BCD converter: FSM encoding and digit geometry.
package lcd_bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  localparam int DIGIT_W     = 4;
  localparam int DIGITS      = 3;
  localparam int CHANNELS    = 3;
  localparam int BCD_W       = DIGIT_W * DIGITS;
  localparam int MAX_VAL_DEF = 999;

endpackage

// File: rtl/lcd_bcd_converter_if.sv
// Host-side bundle of the LCD BCD converter: request, three binary counters,
// nine BCD digits and status flags. The host drives through "master", the
// converter sits on "slave".
interface lcd_bcd_converter_if #(
  parameter int BIN_W = 10
);
  logic             iSTART;
  logic [BIN_W-1:0] bin_250;
  logic [BIN_W-1:0] bin_500;
  logic [BIN_W-1:0] bin_money;
  logic [3:0]       hundreds_250, tens_250, ones_250;
  logic [3:0]       hundreds_500, tens_500, ones_500;
  logic [3:0]       hundreds, tens, ones;
  logic             oBUSY;
  logic             oDONE;
  logic             oSAT;

  modport master (
    output iSTART, bin_250, bin_500, bin_money,
    input  hundreds_250, tens_250, ones_250,
    input  hundreds_500, tens_500, ones_500,
    input  hundreds, tens, ones,
    input  oBUSY, oDONE, oSAT
  );

  modport slave (
    input  iSTART, bin_250, bin_500, bin_money,
    output hundreds_250, tens_250, ones_250,
    output hundreds_500, tens_500, ones_500,
    output hundreds, tens, ones,
    output oBUSY, oDONE, oSAT
  );
endinterface

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add 3 to every BCD digit that is >= 5, then
// shift the 12-bit accumulator left by one, pulling in the next binary bit.
module bcd_dabble_step
  import lcd_bcd_pkg::*;
(
  input  logic [BCD_W-1:0] i_bcd,
  input  logic             i_bit,
  output logic [BCD_W-1:0] o_bcd
);

  logic [BCD_W-1:0] w_adj;

  // Per-digit add-3 correction followed by the one-bit shift.
  always_comb begin
    w_adj = i_bcd;
    for (int d = 0; d < DIGITS; d++) begin
      if (i_bcd[d*DIGIT_W +: DIGIT_W] >= 4'd5) begin
        w_adj[d*DIGIT_W +: DIGIT_W] = i_bcd[d*DIGIT_W +: DIGIT_W] + 4'd3;
      end
    end
    o_bcd = BCD_W'({w_adj, i_bit});
  end

endmodule

// File: rtl/lcd_bcd_converter.sv
// Converts three binary counters into nine BCD digits for the LCD sequencer
// using one double-dabble step time-shared over the channels. All digits are
// published together on the commit cycle so the display never tears.
// Optional macro LCD_BCD_AUTO_START_EN: restart automatically whenever the
// live inputs differ from the last captured snapshot.
module lcd_bcd_converter
  import lcd_bcd_pkg::*;
#(
  parameter int BIN_W   = 10,
  parameter int MAX_VAL = MAX_VAL_DEF
) (
  input  logic                 iCLK,
  input  logic                 iRST,
  lcd_bcd_converter_if.slave   io_bus
);

  localparam int CNT_W = $clog2(BIN_W + 1);

  state_t                            r_state;
  logic [CHANNELS-1:0][BIN_W-1:0]    r_snap;
  logic [CHANNELS-1:0]               r_clamp;
  logic [BCD_W-1:0]                  r_bcd;
  logic [1:0]                        r_ch;
  logic [CNT_W-1:0]                  r_cnt;
  logic                              r_pend;
  logic [CHANNELS-1:0][BCD_W-1:0]    r_shadow;
  logic [CHANNELS-1:0][BCD_W-1:0]    r_out;
  logic                              r_busy;
  logic                              r_done;
  logic                              r_sat;

  logic [CHANNELS-1:0][BIN_W-1:0]    w_in;
  logic [CHANNELS-1:0][BIN_W-1:0]    w_clamped;
  logic [CHANNELS-1:0]               w_over;
  logic                              w_start;
  logic                              w_capture;
  logic                              w_bit;
  logic [BCD_W-1:0]                  w_step;

  assign w_in = {io_bus.bin_money, io_bus.bin_500, io_bus.bin_250};

  // Saturate each live input at MAX_VAL so three BCD digits always suffice.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_clamp
    assign w_over[c]    = (32'(w_in[c]) > 32'(MAX_VAL));
    assign w_clamped[c] = w_over[c] ? BIN_W'(MAX_VAL) : w_in[c];
  end

`ifdef LCD_BCD_AUTO_START_EN
  logic [CHANNELS-1:0][BIN_W-1:0]    r_last;
  assign w_start = io_bus.iSTART | (w_in != r_last);
`else
  assign w_start = io_bus.iSTART;
`endif

  // A new snapshot is taken from IDLE on a request, or at the end of COMMIT
  // when a request arrived during (or on) the previous conversion.
  assign w_capture = ((r_state == ST_IDLE)   && w_start) ||
                     ((r_state == ST_COMMIT) && (r_pend || w_start));

  // The snapshot of the active channel is shifted left every cycle, so its
  // MSB is always the next bit to feed the dabble step.
  assign w_bit = r_snap[r_ch][BIN_W-1];

  bcd_dabble_step u_step (
    .i_bcd (r_bcd),
    .i_bit (w_bit),
    .o_bcd (w_step)
  );

  // Conversion FSM: capture, per-channel shift sequencing, atomic commit.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_state  <= ST_IDLE;
      r_snap   <= '0;
      r_clamp  <= '0;
      r_bcd    <= '0;
      r_ch     <= '0;
      r_cnt    <= '0;
      r_pend   <= 1'b0;
      r_shadow <= '0;
      r_out    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_sat    <= 1'b0;
`ifdef LCD_BCD_AUTO_START_EN
      r_last   <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_pend <= 1'b0;
          if (w_start) begin
            r_busy  <= 1'b1;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (w_start) r_pend <= 1'b1;
          r_snap[r_ch] <= r_snap[r_ch] << 1;
          if (r_cnt == CNT_W'(BIN_W - 1)) begin
            r_shadow[r_ch] <= w_step;
            r_bcd          <= '0;
            r_cnt          <= '0;
            if (r_ch == 2'(CHANNELS - 1)) begin
              r_state <= ST_COMMIT;
            end else begin
              r_ch <= r_ch + 2'd1;
            end
          end else begin
            r_bcd <= w_step;
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_COMMIT: begin
          r_out  <= r_shadow;
          r_done <= 1'b1;
          r_sat  <= |r_clamp;
          r_pend <= 1'b0;
          if (r_pend || w_start) begin
            r_state <= ST_SHIFT;
          end else begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
      // Snapshot overrides the per-state updates of the working registers.
      if (w_capture) begin
        r_snap  <= w_clamped;
        r_clamp <= w_over;
        r_bcd   <= '0;
        r_ch    <= '0;
        r_cnt   <= '0;
`ifdef LCD_BCD_AUTO_START_EN
        r_last  <= w_in;
`endif
      end
    end
  end

  assign io_bus.hundreds_250 = r_out[0][11:8];
  assign io_bus.tens_250     = r_out[0][7:4];
  assign io_bus.ones_250     = r_out[0][3:0];
  assign io_bus.hundreds_500 = r_out[1][11:8];
  assign io_bus.tens_500     = r_out[1][7:4];
  assign io_bus.ones_500     = r_out[1][3:0];
  assign io_bus.hundreds     = r_out[2][11:8];
  assign io_bus.tens         = r_out[2][7:4];
  assign io_bus.ones         = r_out[2][3:0];
  assign io_bus.oBUSY        = r_busy;
  assign io_bus.oDONE        = r_done;
  assign io_bus.oSAT         = r_sat;

endmodule

// File: tb/tb_lcd_bcd_converter.sv
// Scoreboard bench for lcd_bcd_converter: a timeline reference model pushes
// the expected digits and commit cycle for every conversion it predicts; a
// monitor on the falling edge pops and compares whenever oDONE is seen.
module tb_lcd_bcd_converter;

  localparam int BIN_W = 10;
  localparam int LAT   = 3 * BIN_W + 1;

  typedef struct {
    logic [35:0] dig;
    logic        sat;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_done = 0;
  bit   mon_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lcd_bcd_converter_if #(.BIN_W(BIN_W)) bus ();

  lcd_bcd_converter #(.BIN_W(BIN_W), .MAX_VAL(999)) dut (
    .iCLK   (clk),
    .iRST   (rst),
    .io_bus (bus)
  );

  logic [35:0] dut_dig;
  assign dut_dig = {bus.hundreds_250, bus.tens_250, bus.ones_250,
                    bus.hundreds_500, bus.tens_500, bus.ones_500,
                    bus.hundreds, bus.tens, bus.ones};

  // Reference model state
  exp_t        q[$];
  bit          m_active = 1'b0;
  bit          m_pend = 1'b0;
  int          m_done = 0;
  int          m_last[3] = '{0, 0, 0};
  logic [35:0] m_disp = '0;
  logic        m_sat = 1'b0;
  exp_t        mon_e;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [35:0] conv(input int a, input int b, input int c);
    int          v[3];
    int          x;
    logic [35:0] r;
    v = '{a, b, c};
    r = '0;
    for (int i = 0; i < 3; i++) begin
      x = (v[i] > 999) ? 999 : v[i];
      r[35-12*i -: 12] = {4'(x / 100), 4'((x / 10) % 10), 4'(x % 10)};
    end
    return r;
  endfunction

  task automatic snapshot(input int n, input int a, input int b, input int c);
    exp_t e;
    e.dig = conv(a, b, c);
    e.sat = (a > 999) || (b > 999) || (c > 999);
    e.cyc = n + LAT;
    q.push_back(e);
    m_done   = n + LAT;
    m_active = 1'b1;
    m_last   = '{a, b, c};
  endtask

  // Predict what happens at clock edge n given the inputs now on the bus.
  task automatic model_update(input int n);
    int a, b, c;
    bit req;
    a = int'(bus.bin_250);
    b = int'(bus.bin_500);
    c = int'(bus.bin_money);
    req = bus.iSTART;
`ifdef LCD_BCD_AUTO_START_EN
    if (a != m_last[0] || b != m_last[1] || c != m_last[2]) req = 1'b1;
`endif
    if (m_active) begin
      if (n == m_done) begin
        if (m_pend || req) snapshot(n, a, b, c);
        else m_active = 1'b0;
        m_pend = 1'b0;
      end else if (req) begin
        m_pend = 1'b1;
      end
    end else if (req) begin
      snapshot(n, a, b, c);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_pend   = 1'b0;
    m_last   = '{0, 0, 0};
    m_disp   = '0;
    m_sat    = 1'b0;
    q.delete();
  endtask

  task automatic drive(input bit s, input int a, input int b, input int c);
    @(negedge clk);
    #1;
    bus.iSTART    = s;
    bus.bin_250   = BIN_W'(a);
    bus.bin_500   = BIN_W'(b);
    bus.bin_money = BIN_W'(c);
    if (!rst) model_update(cyc + 1);
  endtask

  task automatic hold(input int n);
    repeat (n) drive(1'b0, int'(bus.bin_250), int'(bus.bin_500), int'(bus.bin_money));
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    #1;
    rst = 1'b1;
    bus.iSTART = 1'b0;
    #1;
    check("rstmid_digits", 64'(dut_dig), 64'd0);
    check("rstmid_busy", 64'(bus.oBUSY), 64'd0);
    check("rstmid_done", 64'(bus.oDONE), 64'd0);
    check("rstmid_sat", 64'(bus.oSAT), 64'd0);
    model_reset();
    @(negedge clk);
    #1;
    rst = 1'b0;
    model_update(cyc + 1);
  endtask

  // Monitor: every falling edge compare busy, and either a commit or held digits.
  always @(negedge clk) begin
    if (!rst && mon_en) begin
      check("busy", 64'(bus.oBUSY), 64'(m_active));
      if (bus.oDONE) begin
        n_done++;
        if (q.size() == 0) begin
          check("unexpected_done", 64'(1), 64'(0));
        end else begin
          mon_e = q.pop_front();
          check("done_cycle", 64'(cyc), 64'(mon_e.cyc));
          check("done_digits", 64'(dut_dig), 64'(mon_e.dig));
          check("done_sat", 64'(bus.oSAT), 64'(mon_e.sat));
          m_disp = mon_e.dig;
          m_sat  = mon_e.sat;
        end
      end else begin
        check("held_outputs", 64'({dut_dig, bus.oSAT}), 64'({m_disp, m_sat}));
        if (q.size() > 0 && q[0].cyc < cyc) begin
          mon_e = q.pop_front();
          check("missed_done", 64'(cyc), 64'(mon_e.cyc));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required completion (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0;
    int a, b, c;
    bit s;
    rst = 1'b1;
    bus.iSTART = 1'b0;
    bus.bin_250 = '0;
    bus.bin_500 = '0;
    bus.bin_money = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_digits", 64'(dut_dig), 64'd0);
    check("reset_busy", 64'(bus.oBUSY), 64'd0);
    check("reset_done", 64'(bus.oDONE), 64'd0);
    check("reset_sat", 64'(bus.oSAT), 64'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    model_update(cyc + 1);

    // Idle after reset: nothing happens.
    hold(100);
    check("idle_no_done", 64'(n_done), 64'd0);

    // Basic conversion.
    drive(1'b1, 37, 205, 999);
    hold(40);
    check("basic_digits", 64'(dut_dig), 64'h037205999);
    check("basic_sat", 64'(bus.oSAT), 64'd0);

    // Clamp then recover.
    drive(1'b1, 0, 0, 1023);
    hold(40);
    check("clamp_digits", 64'(dut_dig), 64'h000000999);
    check("clamp_sat", 64'(bus.oSAT), 64'd1);
    drive(1'b1, 0, 0, 500);
    hold(40);
    check("unclamp_digits", 64'(dut_dig), 64'h000000500);
    check("unclamp_sat", 64'(bus.oSAT), 64'd0);

    // Pending restart: two requests during a conversion collapse into one.
    d0 = n_done;
    drive(1'b1, 37, 205, 999);
    hold(4);
    drive(1'b1, 1, 10, 100);
    drive(1'b1, 1, 10, 100);
    hold(90);
    check("pend_done_count", 64'(n_done - d0), 64'd2);
    check("pend_digits", 64'(dut_dig), 64'h001010100);

    // Reset in the middle of a conversion.
    drive(1'b1, 37, 205, 999);
    hold(14);
    reset_pulse();
    hold(40);
    drive(1'b1, 37, 205, 999);
    hold(40);
    check("post_reset_digits", 64'(dut_dig), 64'h037205999);

    // Randomized traffic with occasional requests and input changes.
    a = 0; b = 0; c = 0;
    for (int i = 0; i < 1500; i++) begin
      s = ($urandom_range(15) == 0);
      if ($urandom_range(7) == 0) a = $urandom_range(1023);
      if ($urandom_range(7) == 0) b = $urandom_range(1023);
      if ($urandom_range(7) == 0) c = ($urandom_range(1) == 0) ? $urandom_range(995, 1003) : $urandom_range(1023);
      drive(s, a, b, c);
    end
    hold(100);

`ifdef LCD_BCD_AUTO_START_EN
    drive(1'b0, 0, 0, 0);
    hold(80);
    d0 = n_done;
    drive(1'b0, 0, 42, 0);
    hold(40);
    check("auto_digits", 64'(dut_dig), 64'h000042000);
    check("auto_done_count", 64'(n_done - d0), 64'd1);
    d0 = n_done;
    hold(60);
    check("auto_quiet", 64'(n_done - d0), 64'd0);
`endif

    check("scoreboard_empty", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_bcd_converter.md
Name: lcd_bcd_converter

Overview:
- Upstream feeder of the LCD text sequencer.
- Converts three binary counters (250 ml bottles, 500 ml bottles, money points) into the 3-digit BCD nibbles the sequencer displays.
- Uses a sequential double-dabble engine, time-shared across the three channels.
- Publishes all nine digits atomically, so the LCD never shows a half-updated line.

Parameters:
- BIN_W, 10, width of each binary input.
- MAX_VAL, 999, saturation ceiling; inputs above it are clamped.

Ports:
- iCLK  in  1  system clock
- iRST  in  1  asynchronous, active-high reset
- iSTART  in  1  conversion request; sampled each cycle
- bin_250  in  BIN_W  count of 250 ml bottles
- bin_500  in  BIN_W  count of 500 ml bottles
- bin_money  in  BIN_W  money/points total
- hundreds_250, tens_250, ones_250  out  4 each  BCD digits, channel 0
- hundreds_500, tens_500, ones_500  out  4 each  BCD digits, channel 1
- hundreds, tens, ones  out  4 each  BCD digits, channel 2 (money)
- oBUSY  out  1  high from capture through commit
- oDONE  out  1  one-cycle pulse when the digit outputs update
- oSAT  out  1  high if any channel was clamped in the last committed conversion

Behaviour:
- Reset (async, iRST=1):
  - All digit outputs, oBUSY, oDONE and oSAT are 0.
  - FSM goes to IDLE; channel index, shift counter, pending flag and shadow registers are cleared.
  - A reset mid-conversion aborts it with no oDONE.
- FSM states: IDLE, SHIFT, COMMIT.
- IDLE:
  - On iSTART=1, snapshot all three inputs at that edge, clamping each to MAX_VAL (record per-channel clamp bits).
  - Then clear the BCD accumulator, set channel=0, count=0, oBUSY=1, and go to SHIFT.
- SHIFT, one cycle per input bit:
  - For each BCD digit of the accumulator that is >=5, add 3.
  - Then shift {bcd[11:0], bin} left by one bit, taking the MSB of the current channel's snapshot.
  - After BIN_W cycles, write the 12-bit result to that channel's shadow register and reset the accumulator/count.
  - If channel<2, increment channel and stay in SHIFT; there is no idle gap between channels.
  - After channel 2, go to COMMIT.
- COMMIT, one cycle:
  - Copy all shadows to the digit outputs simultaneously.
  - oDONE=1 for this cycle only; oSAT = OR of the clamp bits.
  - If pending=0: go to IDLE, oBUSY=0.
  - If pending=1: clear pending, re-snapshot the inputs at this edge and go to SHIFT (oBUSY stays 1).
- Latency:
  - Digit outputs and oDONE become visible 3*BIN_W+1 cycles after the edge that sampled iSTART (31 cycles by default).
  - Back-to-back conversions via pending are spaced by exactly 3*BIN_W+1 cycles between oDONE pulses.
- iSTART while oBUSY=1 sets pending; multiple requests collapse into one. iSTART in COMMIT also sets pending.
- Digit outputs hold their previous values during a conversion. Only the COMMIT edge changes them.
- Arithmetic:
  - The clamped value is always <=999, so the three BCD digits never overflow.
  - BIN_W<10 is legal: upper digits simply read 0.
  - BIN_W>10 is legal: the clamp guards the range.

Optional Feature:
- Macro: LCD_BCD_AUTO_START_EN.
- Defined: a registered copy of the last snapshot is kept. While in IDLE, any difference between the live inputs and that copy acts as an internal iSTART, so the display tracks the counters without a host pulse. iSTART still works. A change arriving during SHIFT sets pending.
- Undefined: conversions start only on iSTART; no comparator or copy registers exist.

Decomposition:
- Shared package lcd_bcd_pkg holds:
  - FSM state encoding (IDLE/SHIFT/COMMIT)
  - BCD digit width (4)
  - digits per channel (3)
  - channel count (3)
  - default MAX_VAL
- Sub-module bcd_dabble_step: purely combinational add-3 adjust plus one-bit shift on {12-bit bcd, next bit}, instantiated once.
- Channel multiplexing, counters and the FSM stay in the top module.

Test Plan:
- Reset then idle: iRST=1 then 0 with no iSTART -> all digits 0, oBUSY=0, oDONE never asserted over 100 cycles.
- Basic conversion: bin_250=37, bin_500=205, bin_money=999, iSTART pulse -> 31 cycles later oDONE=1 for 1 cycle; digits 0/3/7, 2/0/5, 9/9/9; oSAT=0; outputs unchanged before that cycle.
- Clamp: bin_money=1023, others 0 -> money digits 9/9/9, oSAT=1; a following conversion with bin_money=500 -> 5/0/0, oSAT=0.
- Pending restart: start with 37/205/999; at cycle 5 change inputs to 1/10/100 and pulse iSTART twice -> first oDONE shows 37/205/999; second oDONE exactly 31 cycles later shows 1/10/100; no third oDONE.
- Reset mid-operation: iRST asserted at cycle 15 of a conversion -> immediately all outputs 0, oBUSY=0; no oDONE follows; the next iSTART converts normally.
- Auto start (LCD_BCD_AUTO_START_EN defined): change bin_500 from 0 to 42 with no iSTART -> oDONE after 31 cycles with digits 0/4/2; constant inputs -> no further oDONE.
